// File: rtl/mem_access_unit.sv
// Load/store stage: one req/ack bus transaction per load or store, with ack timeout and load formatting.
// Optional feature macro MISALIGN_TRAP_EN: misaligned H/W accesses complete at once with err, no bus cycle.
module mem_access_unit #(
  parameter int unsigned ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [1:0]       lo_q;
  logic [2:0]       f3_q;
  logic [CNT_W-1:0] cnt;
  logic             req_c;
  logic             trap_c;
  logic             timeout_c;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {lo, 3'b000};
    h  = lo[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   fmt_load = f3[2] ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   fmt_load = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   strobe = 4'b0001 << lo;
      2'b01:   strobe = 4'b0011 << {lo[1], 1'b0};
      default: strobe = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   replicate = {4{w[7:0]}};
      2'b01:   replicate = {2{w[15:0]}};
      default: replicate = w;
    endcase
  endfunction

  assign req_c     = mem_rd | mem_wr;
  assign timeout_c = (ACK_TIMEOUT != 0) && (cnt == CNT_W'(ACK_TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
  assign trap_c = ((funct3[1:0] == 2'b01) && addr[0]) || (funct3[1] && (addr[1:0] != 2'b00));
`else
  assign trap_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state and handshake outputs
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    case (state)
      IDLE: begin
        busy = req_c;
        if (req_c) next_state = trap_c ? DONE : REQ;
      end
      REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
        if (bus_ack || timeout_c) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (rst) busy = 1'b0;
  end

  // Request latch, timeout counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wstrb <= '0;
      bus_wdata <= '0;
      lo_q      <= '0;
      f3_q      <= '0;
      cnt       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_c) begin
            bus_we    <= mem_wr;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_wstrb <= mem_wr ? strobe(funct3[1:0], addr[1:0]) : 4'b0000;
            bus_wdata <= replicate(funct3[1:0], wdata);
            lo_q      <= addr[1:0];
            f3_q      <= funct3;
            cnt       <= '0;
            if (trap_c) begin
              rdata <= '0;
              err   <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (bus_ack) begin
            rdata <= bus_we ? 32'd0 : fmt_load(f3_q, lo_q, bus_rdata);
            err   <= 1'b0;
          end else if (timeout_c) begin
            rdata <= '0;
            err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a transaction-level model.
module tb_mem_access_unit;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_access_unit #(.ACK_TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int req_hi = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus_req) req_hi <= req_hi + 1;

  int vectors = 0;
  int miscompares = 0;

  // Expected transaction, filled by setup()
  bit          active = 1'b0;
  int          tn = 0;
  int          len = 0;
  bit          e_mis;
  logic        e_we;
  logic [31:0] e_addr;
  logic [3:0]  e_strb;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata;
  logic        e_err;
  logic [31:0] held_rdata = '0;
  logic        held_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic void setup(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdw, input int w);
    int sz;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? 2 * int'(a[1]) : 0;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v    = (rdw >> (8 * off)) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    e_mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    e_mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`endif
    e_we    = wr;
    e_addr  = a & 32'hFFFF_FFFC;
    e_strb  = wr ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    e_wdata = (sz == 1) ? 32'(wd[7:0]) * 32'h0101_0101 :
              (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : wd;
    len     = e_mis ? 0 : (w < T) ? w + 1 : T;
    e_err   = e_mis || (w >= T);
    e_rdata = (e_err || wr) ? 32'd0 : v;
    if (rd == 1'b0 && wr == 1'b0) len = 0;
  endfunction

  // Cycle-by-cycle compare against the expected transaction
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_req", 32'(bus_req), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_bus_we", 32'(bus_we), 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_wstrb", 32'(bus_wstrb), 0);
      chk("rst_wdata", bus_wdata, 0);
    end else if (active && cyc == tn) begin
      chk("req_busy", 32'(busy), 1);
      chk("req_bus_req", 32'(bus_req), 0);
      chk("req_done", 32'(done), 0);
    end else if (active && cyc > tn && cyc <= tn + len) begin
      chk("bus_busy", 32'(busy), 1);
      chk("bus_req", 32'(bus_req), 1);
      chk("bus_done", 32'(done), 0);
      chk("bus_we", 32'(bus_we), 32'(e_we));
      chk("bus_addr", bus_addr, e_addr);
      chk("bus_wstrb", 32'(bus_wstrb), 32'(e_strb));
      if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
      chk("bus_rdata_hold", rdata, held_rdata);
    end else if (active && cyc == tn + len + 1) begin
      chk("done", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_req", 32'(bus_req), 0);
      chk("done_rdata", rdata, e_rdata);
      chk("done_err", 32'(err), 32'(e_err));
      held_rdata = e_rdata;
      held_err   = e_err;
    end else begin
      chk("idle_busy", 32'(busy), 0);
      chk("idle_req", 32'(bus_req), 0);
      chk("idle_done", 32'(done), 0);
      chk("idle_rdata", rdata, held_rdata);
      chk("idle_err", 32'(err), 32'(held_err));
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdw, input int w);
    @(posedge clk); #1;
    setup(rd, wr, f3, a, wd, rdw, w);
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'b0;
    tn = cyc;
    active = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      if (i == w) begin bus_ack = 1'b1; bus_rdata = rdw; end
      else begin bus_ack = 1'b0; bus_rdata = $urandom; end
    end
    @(posedge clk); #1;
    bus_ack = 1'b0;
    bus_rdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mem_rd = 1'b0; mem_wr = 1'b0; bus_ack = 1'b0;
      addr = $urandom; wdata = $urandom;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int base;
    logic [2:0] r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // LB / LBU, zero-wait ack
    run_txn(1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    chk("lb_latency", 32'(cyc - tn), 2);
    chk("lb_done", 32'(done), 1);
    idle(1);
    run_txn(1, 0, 3'b100, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    idle(1);

    // SH with three wait cycles
    base = req_hi;
    run_txn(0, 1, 3'b001, 32'h0000_2002, 32'h1234_5678, 32'hDEAD_BEEF, 3);
    chk("sh_req_cycles", 32'(req_hi - base), 4);
    chk("sh_wstrb", 32'(bus_wstrb), 32'b1100);
    chk("sh_wdata", bus_wdata, 32'h5678_5678);
    chk("sh_rdata", rdata, 0);
    idle(1);

    // LW never acked: timeout
    base = req_hi;
    run_txn(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 1000);
    chk("to_req_cycles", 32'(req_hi - base), 8);
    chk("to_err", 32'(err), 1);
    chk("to_rdata", rdata, 0);
    idle(1);

    // LW misaligned
    base = req_hi;
    run_txn(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req_cycles", 32'(req_hi - base), 0);
    chk("mis_latency", 32'(cyc - tn), 1);
    chk("mis_err", 32'(err), 1);
    chk("mis_rdata", rdata, 0);
`else
    chk("mis_req_cycles", 32'(req_hi - base), 1);
    chk("mis_bus_addr", bus_addr, 32'h0000_3000);
    chk("mis_err", 32'(err), 0);
    chk("mis_rdata", rdata, 32'hCAFE_F00D);
`endif
    idle(1);

    // Randomized traffic, including ack on the last allowed cycle and timeouts
    for (int n = 0; n < 60; n++) begin
      r = 3'($urandom_range(1, 3));
      run_txn(r[0], r[1], 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
              int'($urandom_range(0, 9)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    // Async reset in the middle of a bus request
    @(posedge clk); #1;
    setup(1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 1000);
    mem_rd = 1'b1; mem_wr = 1'b0; funct3 = 3'b010; addr = 32'h0000_5000;
    tn = cyc;
    active = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("pre_rst_req", 32'(bus_req), 1);
    #1 rst = 1'b1;
    active = 1'b0;
    held_rdata = '0;
    held_err = 1'b0;
    #1;
    chk("async_rst_req", 32'(bus_req), 0);
    chk("async_rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    mem_rd = 1'b0;
    rst = 1'b0;
    idle(1);
    run_txn(1, 0, 3'b101, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 1);
    chk("post_rst_rdata", rdata, 32'h0000_8001);
    chk("post_rst_err", 32'(err), 0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
